// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding select and load-use stall control for
// a five-stage pipeline. Shadows the destination of the instructions in EX
// and MEM, matches them against the ID sources, and registers the EX-stage
// operand-mux selects. A load in EX feeding the ID instruction stalls PC and
// IF/ID for one cycle while a bubble is injected into EX.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UseRs,
    input  logic              ID_UseRt,
    input  logic              ID_RegWr,
    input  logic [REG_AW-1:0] ID_Rw,
    input  logic              ID_MemToReg,
    input  logic              Flush,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic              Stall,
    output logic              PC_Wr,
    output logic              IFID_Wr,
    output logic [CNT_W-1:0]  StallCnt
);

    // Operand-mux select encodings seen by the EX stage.
    localparam logic [1:0] SEL_MEM = 2'b00;  // producer now in MEM
    localparam logic [1:0] SEL_WB  = 2'b01;  // producer now in WB
    localparam logic [1:0] SEL_RF  = 2'b10;  // register-file read is current

    // EX and MEM shadow slots.
    logic              ex_regwr_q,  ex_regwr_d;
    logic [REG_AW-1:0] ex_rw_q,     ex_rw_d;
    logic              ex_load_q,   ex_load_d;
    logic              mem_regwr_q;
    logic [REG_AW-1:0] mem_rw_q;

    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic ex_live, mem_live;
    logic match_ex_a, match_ex_b, match_mem_a, match_mem_b;
    logic stall;

    // Source matching, load-use detection and next-state selection.
    always_comb begin
        ex_live  = ex_regwr_q  && (ex_rw_q  != '0);
        mem_live = mem_regwr_q && (mem_rw_q != '0);

        match_ex_a  = ID_UseRs && ex_live  && (ex_rw_q  == ID_Rs);
        match_ex_b  = ID_UseRt && ex_live  && (ex_rw_q  == ID_Rt);
        match_mem_a = ID_UseRs && mem_live && (mem_rw_q == ID_Rs);
        match_mem_b = ID_UseRt && mem_live && (mem_rw_q == ID_Rt);

        // A load result is not available until after MEM, so a consumer
        // directly behind it must wait one cycle. Flush kills the consumer.
        stall = !Flush && ex_load_q && (match_ex_a || match_ex_b);

        // Defaults: the ID instruction moves into EX unchanged.
        ex_regwr_d  = ID_RegWr;
        ex_rw_d     = ID_Rw;
        ex_load_d   = ID_MemToReg;
        fwd_a_d     = SEL_RF;
        fwd_b_d     = SEL_RF;
        stall_cnt_d = stall_cnt_q;

        if (stall || Flush) begin
            // Bubble: no write, no load; its operands are don't-care.
            ex_regwr_d = 1'b0;
            ex_rw_d    = '0;
            ex_load_d  = 1'b0;
        end else begin
            // Youngest producer (EX) wins over the older one (MEM).
            if (match_ex_a)       fwd_a_d = SEL_MEM;
            else if (match_mem_a) fwd_a_d = SEL_WB;
            if (match_ex_b)       fwd_b_d = SEL_MEM;
            else if (match_mem_b) fwd_b_d = SEL_WB;
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Pipeline shadow slots, registered selects and the saturating counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_regwr_q  <= 1'b0;
            ex_rw_q     <= '0;
            ex_load_q   <= 1'b0;
            mem_regwr_q <= 1'b0;
            mem_rw_q    <= '0;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_regwr_q  <= ex_regwr_d;
            ex_rw_q     <= ex_rw_d;
            ex_load_q   <= ex_load_d;
            mem_regwr_q <= ex_regwr_q;
            mem_rw_q    <= ex_rw_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FwdA     = fwd_a_q;
    assign FwdB     = fwd_b_q;
    assign Stall    = stall;
    assign PC_Wr    = !stall;
    assign IFID_Wr  = !stall;
    assign StallCnt = stall_cnt_q;

endmodule
